pg_port_rst_seq: RTL and testbench
==================================

Name: pg_port_rst_seq

Overview:
- Parametrised per-port reset sequencer for the port gasket; the next generation of the single-slot port reset logic.
- Generates an independent reset for each of NUM_PORTS PCIe ports in the PR slot.
- Each port's reset comes from its FLR pulse, its CSR soft-reset level, or the global PR reset.
- Each request drains the port's traffic (with a timeout), holds reset for a programmable minimum, then releases. FLR completion is acknowledged back to the PCIe sideband logic.

Parameters:
- NUM_PORTS, 4: number of ports/channels sequenced; range 1..64.
- HOLD_CYCLES, 16: minimum cycles o_port_rst_n is held low per sequence; must be >=2.
- DRAIN_TIMEOUT, 4096: maximum cycles spent in DRAIN before reset is forced; must be >=1.
- CNT_W, $clog2(max(HOLD_CYCLES,DRAIN_TIMEOUT)+1): width of the per-port counter. Derived; never overridden.

Ports:
- clk, in, 1: single clock; all logic runs in this domain.
- reset, in, 1: synchronous, active-high.
- i_pr_reset, in, 1: level; global PR reset applied to all ports, bypassing drain.
- i_flr_req, in, NUM_PORTS: one-cycle FLR pulse per port.
- i_soft_rst_req, in, NUM_PORTS: CSR soft-reset level per port.
- i_drain_done, in, NUM_PORTS: level; port has no outstanding traffic.
- i_err_clr, in, NUM_PORTS: pulse; clears the matching o_timeout_err bit.
- o_port_rst_n, out, NUM_PORTS: active-low reset to each port.
- o_drain_req, out, NUM_PORTS: asks the port's traffic controller to stop issuing and drain.
- o_flr_done, out, NUM_PORTS: one-cycle pulse when an FLR-initiated sequence completes.
- o_busy, out, NUM_PORTS: high whenever the port is not in IDLE.
- o_timeout_err, out, NUM_PORTS: sticky; set when a drain timed out.

Behaviour:
- Each port has an identical, independent FSM with states IDLE, DRAIN, ASSERT, HOLD, WAIT_REL.
- Reset (reset=1), per port:
  - state=HOLD, counter=HOLD_CYCLES-1.
  - o_port_rst_n=0, o_drain_req=0, o_flr_done=0, o_busy=1, o_timeout_err=0, flr_pend=0.
  - After reset deasserts, ports stay in reset for HOLD_CYCLES cycles, then release.
- IDLE:
  - Outputs: o_port_rst_n=1, o_busy=0.
  - i_flr_req pulse: set flr_pend and go to DRAIN.
  - i_soft_rst_req=1: go to DRAIN.
  - Both in the same cycle: single DRAIN, with flr_pend set.
  - Transition to DRAIN loads counter=DRAIN_TIMEOUT-1.
- DRAIN:
  - o_drain_req=1; o_port_rst_n stays 1.
  - If i_drain_done=1, go to ASSERT next cycle.
  - Otherwise, when counter reaches 0, set o_timeout_err and go to ASSERT.
  - Otherwise decrement the counter.
  - Drain latency is therefore 1 cycle minimum and DRAIN_TIMEOUT cycles maximum.
- ASSERT:
  - Lasts one cycle: o_port_rst_n=0, o_drain_req=0.
  - Loads counter=HOLD_CYCLES-2, then goes to HOLD.
  - Reset is therefore low for HOLD_CYCLES cycles including ASSERT.
- HOLD:
  - o_port_rst_n=0; decrement the counter.
  - At 0: if i_soft_rst_req=1, go to WAIT_REL; else go to IDLE.
- WAIT_REL:
  - o_port_rst_n=0; remain while i_soft_rst_req=1.
  - When i_soft_rst_req falls, go to IDLE.
- Release and FLR acknowledge:
  - On the cycle the FSM enters IDLE from HOLD or WAIT_REL, o_port_rst_n goes to 1.
  - If flr_pend=1 at that point, o_flr_done pulses for exactly one cycle on that same cycle, and flr_pend clears.
- FLR arriving mid-sequence:
  - An i_flr_req pulse in DRAIN, ASSERT, HOLD or WAIT_REL sets flr_pend and is merged into the current sequence; it does not restart it.
  - A pulse in the same cycle as the IDLE entry is not merged: it starts a new sequence on the next cycle, and the current sequence's done pulse still fires.
- PR reset (highest priority over all other requests):
  - While i_pr_reset=1, every port is forced to ASSERT/HOLD behaviour: o_port_rst_n=0, o_drain_req=0, with no drain wait.
  - The counter is reloaded to HOLD_CYCLES-2 every cycle i_pr_reset=1.
  - On i_pr_reset deassertion, each port completes HOLD normally.
  - flr_pend is preserved across PR reset.
- o_timeout_err:
  - Cleared by i_err_clr.
  - Set wins over clear when both happen in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Ports never interact except through i_pr_reset.

Decomposition:
- Shared package (pg_pkg): typedef enum logic [2:0] t_port_rst_state {IDLE, DRAIN, ASSERT, HOLD, WAIT_REL}, plus the CNT_W helper function.
- Sub-module pg_port_rst_ch:
  - One channel FSM plus its counter and flr_pend.
  - Instantiated NUM_PORTS times in a generate loop.
  - The top level only fans out i_pr_reset and concatenates the outputs.

Test Plan:
- Power-up, NUM_PORTS=4, HOLD_CYCLES=16: deassert reset at cycle 0 -> all o_port_rst_n low through cycle 15, high at cycle 16; o_busy=0 afterwards.
- FLR on port 2 with i_drain_done[2]=1 immediately: pulse at cycle T -> o_drain_req[2] high at T+1; o_port_rst_n[2] low for cycles T+2..T+17; o_flr_done[2] pulses at T+18. Ports 0, 1 and 3 are undisturbed.
- Drain timeout with DRAIN_TIMEOUT=8 and i_drain_done[1] held 0: soft-reset pulse -> reset asserts after 8 DRAIN cycles; o_timeout_err[1]=1 and stays sticky. i_err_clr[1] clears it; set and clear in the same cycle leave it at 1.
- Soft-reset level on port 0 held for 100 cycles -> o_port_rst_n[0] stays low until i_soft_rst_req[0] falls, then high next cycle; no o_flr_done pulse.
- FLR pulse on port 3 mid-HOLD -> single sequence, exactly one o_flr_done[3] pulse. A second FLR on the IDLE-entry cycle -> a second full sequence and a second done pulse.
- i_pr_reset asserted during port 1 DRAIN and held 5 cycles -> all ports low immediately. After release, all ports high after a further HOLD_CYCLES-1 cycles; port 1's pending FLR is acknowledged at release.

Source files
------------

// File: rtl/pg_pkg.sv
// Shared state encoding and sizing helper for the port gasket per-port reset sequencer.
package pg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ASSERT,
        HOLD,
        WAIT_REL
    } t_port_rst_state;

    // Counter must hold the larger of the hold length and the drain timeout.
    function automatic int cnt_width(input int hold_cycles, input int drain_timeout);
        int max_cnt;
        max_cnt = (hold_cycles > drain_timeout) ? hold_cycles : drain_timeout;
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/pg_port_rst_ch.sv
// One port's reset sequencer: drain with timeout, timed reset hold, optional
// soft-reset extension, and FLR completion acknowledge.
module pg_port_rst_ch #(
    parameter int HOLD_CYCLES   = 16,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pr_reset,
    input  logic i_flr_req,
    input  logic i_soft_rst_req,
    input  logic i_drain_done,
    input  logic i_err_clr,
    output logic o_port_rst_n,
    output logic o_drain_req,
    output logic o_flr_done,
    output logic o_busy,
    output logic o_timeout_err
);
    import pg_pkg::*;

    localparam int CNT_W = cnt_width(HOLD_CYCLES, DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_INIT   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 2);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    t_port_rst_state state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic flr_pend, flr_pend_nxt;
    logic flr_done_nxt;
    logic timeout_set;
    logic port_rst_n_nxt, drain_req_nxt, busy_nxt, timeout_err_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HOLD;
            cnt           <= HOLD_INIT;
            flr_pend      <= 1'b0;
            o_port_rst_n  <= 1'b0;
            o_drain_req   <= 1'b0;
            o_flr_done    <= 1'b0;
            o_busy        <= 1'b1;
            o_timeout_err <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            flr_pend      <= flr_pend_nxt;
            o_port_rst_n  <= port_rst_n_nxt;
            o_drain_req   <= drain_req_nxt;
            o_flr_done    <= flr_done_nxt;
            o_busy        <= busy_nxt;
            o_timeout_err <= timeout_err_nxt;
        end
    end

    // A pulse arriving on the release edge belongs to the next sequence, so the
    // pending flag is reloaded from it while the old pending flag is acknowledged.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        flr_pend_nxt = flr_pend | i_flr_req;
        flr_done_nxt = 1'b0;
        timeout_set  = 1'b0;

        if (i_pr_reset) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_RELOAD;
        end else begin
            case (state)
                IDLE: begin
                    if (i_flr_req || i_soft_rst_req || flr_pend) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (i_drain_done) begin
                        state_nxt = ASSERT;
                    end else if (cnt == '0) begin
                        state_nxt   = ASSERT;
                        timeout_set = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ASSERT: begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_RELOAD;
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_ONE;
                    end else if (i_soft_rst_req) begin
                        state_nxt = WAIT_REL;
                    end else begin
                        state_nxt    = IDLE;
                        flr_done_nxt = flr_pend;
                        flr_pend_nxt = i_flr_req;
                    end
                end
                WAIT_REL: begin
                    if (!i_soft_rst_req) begin
                        state_nxt    = IDLE;
                        flr_done_nxt = flr_pend;
                        flr_pend_nxt = i_flr_req;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        port_rst_n_nxt  = (state_nxt == IDLE) || (state_nxt == DRAIN);
        drain_req_nxt   = (state_nxt == DRAIN);
        busy_nxt        = (state_nxt != IDLE);
        timeout_err_nxt = timeout_set | (o_timeout_err & ~i_err_clr);
    end

endmodule

// File: rtl/pg_port_rst_seq.sv
// Per-port reset sequencer for the port gasket: one independent channel per
// PCIe port, sharing only the global PR reset.
module pg_port_rst_seq #(
    parameter int NUM_PORTS     = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_pr_reset,
    input  logic [NUM_PORTS-1:0] i_flr_req,
    input  logic [NUM_PORTS-1:0] i_soft_rst_req,
    input  logic [NUM_PORTS-1:0] i_drain_done,
    input  logic [NUM_PORTS-1:0] i_err_clr,
    output logic [NUM_PORTS-1:0] o_port_rst_n,
    output logic [NUM_PORTS-1:0] o_drain_req,
    output logic [NUM_PORTS-1:0] o_flr_done,
    output logic [NUM_PORTS-1:0] o_busy,
    output logic [NUM_PORTS-1:0] o_timeout_err
);
    import pg_pkg::*;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        pg_port_rst_ch #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .i_pr_reset    (i_pr_reset),
            .i_flr_req     (i_flr_req[p]),
            .i_soft_rst_req(i_soft_rst_req[p]),
            .i_drain_done  (i_drain_done[p]),
            .i_err_clr     (i_err_clr[p]),
            .o_port_rst_n  (o_port_rst_n[p]),
            .o_drain_req   (o_drain_req[p]),
            .o_flr_done    (o_flr_done[p]),
            .o_busy        (o_busy[p]),
            .o_timeout_err (o_timeout_err[p])
        );
    end

endmodule

// File: tb/tb_pg_port_rst_seq.sv
// Bench for pg_port_rst_seq: directed scenarios then random traffic, all outputs
// compared every cycle against a timing model of the sequencer's rules.
module tb_pg_port_rst_seq;

    localparam int NP   = 4;
    localparam int HOLD = 16;
    localparam int TO   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pr_reset;
    logic [NP-1:0] flr_req, soft_rst_req, drain_done, err_clr;
    logic [NP-1:0] port_rst_n, drain_req, flr_done, busy, timeout_err;

    int checks = 0;
    int errors = 0;
    int done3_count = 0;

    // Model: remaining low cycles, drain age, soft-release wait, pending FLR.
    int m_low [NP];
    int m_age [NP];
    bit m_drain [NP];
    bit m_wait [NP];
    bit m_pend [NP];
    bit m_err [NP];
    bit m_done [NP];

    pg_port_rst_seq #(
        .NUM_PORTS    (NP),
        .HOLD_CYCLES  (HOLD),
        .DRAIN_TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_pr_reset    (pr_reset),
        .i_flr_req     (flr_req),
        .i_soft_rst_req(soft_rst_req),
        .i_drain_done  (drain_done),
        .i_err_clr     (err_clr),
        .o_port_rst_n  (port_rst_n),
        .o_drain_req   (drain_req),
        .o_flr_done    (flr_done),
        .o_busy        (busy),
        .o_timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge();
        for (int p = 0; p < NP; p++) begin
            logic f, s, pold;
            f = flr_req[p];
            s = soft_rst_req[p];
            pold = m_pend[p];
            m_done[p] = 1'b0;
            if (reset) begin
                m_low[p] = HOLD;
                m_drain[p] = 1'b0;
                m_wait[p] = 1'b0;
                m_pend[p] = 1'b0;
                m_err[p] = 1'b0;
            end else begin
                if (err_clr[p]) m_err[p] = 1'b0;
                if (pr_reset) begin
                    m_pend[p] = pold | f;
                    m_drain[p] = 1'b0;
                    m_wait[p] = 1'b0;
                    m_low[p] = HOLD - 1;
                end else if (m_drain[p]) begin
                    m_pend[p] = pold | f;
                    if (drain_done[p] || (m_age[p] + 1 == TO)) begin
                        if (!drain_done[p]) m_err[p] = 1'b1;
                        m_drain[p] = 1'b0;
                        m_low[p] = HOLD;
                    end else begin
                        m_age[p]++;
                    end
                end else if (m_low[p] > 1) begin
                    m_low[p]--;
                    m_pend[p] = pold | f;
                end else if (m_low[p] == 1 && s) begin
                    m_low[p] = 0;
                    m_wait[p] = 1'b1;
                    m_pend[p] = pold | f;
                end else if (m_low[p] == 1 || (m_wait[p] && !s)) begin
                    m_low[p] = 0;
                    m_wait[p] = 1'b0;
                    m_done[p] = pold;
                    m_pend[p] = f;
                end else if (m_wait[p]) begin
                    m_pend[p] = pold | f;
                end else if (f || s || pold) begin
                    m_drain[p] = 1'b1;
                    m_age[p] = 0;
                    m_pend[p] = pold | f;
                end
            end
        end
    endtask

    task automatic checkModel();
        logic [NP-1:0] e_rst_n, e_drain, e_done, e_busy, e_err;
        for (int p = 0; p < NP; p++) begin
            e_rst_n[p] = !((m_low[p] > 0) || m_wait[p]);
            e_drain[p] = m_drain[p];
            e_done[p]  = m_done[p];
            e_busy[p]  = m_drain[p] || (m_low[p] > 0) || m_wait[p];
            e_err[p]   = m_err[p];
        end
        checkOutput("port_rst_n", 64'(port_rst_n), 64'(e_rst_n));
        checkOutput("drain_req", 64'(drain_req), 64'(e_drain));
        checkOutput("flr_done", 64'(flr_done), 64'(e_done));
        checkOutput("busy", 64'(busy), 64'(e_busy));
        checkOutput("timeout_err", 64'(timeout_err), 64'(e_err));
        if (flr_done[3] === 1'b1) done3_count++;
    endtask

    // Runs n cycles; flr_req and err_clr are pulses and clear after the first.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelEdge();
            #1;
            checkModel();
            flr_req = '0;
            err_clr = '0;
        end
    endtask

    initial begin
        reset = 1'b1;
        pr_reset = 1'b0;
        flr_req = '0;
        soft_rst_req = '0;
        drain_done = '1;
        err_clr = '0;
        for (int p = 0; p < NP; p++) begin
            m_low[p] = 0;
            m_age[p] = 0;
            m_drain[p] = 0;
            m_wait[p] = 0;
            m_pend[p] = 0;
            m_err[p] = 0;
            m_done[p] = 0;
        end
        #2;

        // Power-up: reset low for HOLD cycles after reset deasserts.
        applyStimulus(3);
        checkOutput("reset_busy", 64'(busy), 64'hF);
        reset = 1'b0;
        applyStimulus(15);
        checkOutput("powerup_still_low", 64'(port_rst_n), 64'h0);
        applyStimulus(1);
        checkOutput("powerup_released", 64'(port_rst_n), 64'hF);
        checkOutput("powerup_idle", 64'(busy), 64'h0);
        applyStimulus(3);

        // FLR on port 2 with immediate drain completion.
        flr_req = 4'b0100;
        applyStimulus(1);
        checkOutput("flr2_drain_req", 64'(drain_req), 64'h4);
        applyStimulus(1);
        checkOutput("flr2_assert", 64'(port_rst_n), 64'hB);
        applyStimulus(15);
        checkOutput("flr2_hold_end", 64'(port_rst_n), 64'hB);
        applyStimulus(1);
        checkOutput("flr2_release", 64'(port_rst_n), 64'hF);
        checkOutput("flr2_done", 64'(flr_done), 64'h4);
        applyStimulus(3);

        // Drain timeout on port 1, then set-and-clear in the same cycle.
        drain_done = 4'b1101;
        soft_rst_req = 4'b0010;
        applyStimulus(1);
        soft_rst_req = '0;
        applyStimulus(7);
        checkOutput("timeout_pre_err", 64'(timeout_err), 64'h0);
        applyStimulus(1);
        checkOutput("timeout_err_set", 64'(timeout_err), 64'h2);
        applyStimulus(20);
        checkOutput("timeout_sticky", 64'(timeout_err), 64'h2);
        soft_rst_req = 4'b0010;
        applyStimulus(1);
        soft_rst_req = '0;
        applyStimulus(7);
        err_clr = 4'b0010;
        applyStimulus(1);
        checkOutput("timeout_set_wins", 64'(timeout_err), 64'h2);
        applyStimulus(20);
        err_clr = 4'b0010;
        applyStimulus(1);
        checkOutput("timeout_cleared", 64'(timeout_err), 64'h0);
        drain_done = '1;
        applyStimulus(2);

        // Soft-reset level held on port 0.
        soft_rst_req = 4'b0001;
        applyStimulus(100);
        checkOutput("soft_held_low", 64'(port_rst_n[0]), 64'h0);
        soft_rst_req = '0;
        applyStimulus(1);
        checkOutput("soft_release", 64'(port_rst_n[0]), 64'h1);
        checkOutput("soft_no_done", 64'(flr_done), 64'h0);
        applyStimulus(3);

        // Port 3: FLR merged mid-HOLD, then a second FLR on the release edge.
        done3_count = 0;
        flr_req = 4'b1000;
        applyStimulus(6);
        flr_req = 4'b1000;
        applyStimulus(10);
        applyStimulus(1);
        flr_req = 4'b1000;
        applyStimulus(1);
        checkOutput("flr3_first_done", 64'(flr_done[3]), 64'h1);
        applyStimulus(25);
        checkOutput("flr3_done_count", 64'(done3_count), 64'd2);

        // PR reset while port 1 drains an FLR.
        drain_done = 4'b1101;
        flr_req = 4'b0010;
        applyStimulus(3);
        pr_reset = 1'b1;
        applyStimulus(1);
        checkOutput("pr_all_low", 64'(port_rst_n), 64'h0);
        checkOutput("pr_no_drain", 64'(drain_req), 64'h0);
        applyStimulus(4);
        pr_reset = 1'b0;
        drain_done = '1;
        applyStimulus(14);
        checkOutput("pr_hold_tail", 64'(port_rst_n), 64'h0);
        applyStimulus(1);
        checkOutput("pr_release", 64'(port_rst_n), 64'hF);
        checkOutput("pr_flr1_ack", 64'(flr_done), 64'h2);
        applyStimulus(3);

        // Random traffic, alternating between fast and slow drain epochs.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(31) == 0) soft_rst_req[p] = ~soft_rst_req[p];
                flr_req[p] = ($urandom_range(15) == 0);
                err_clr[p] = ($urandom_range(15) == 0);
                if (i[8]) drain_done[p] = ($urandom_range(9) == 0);
                else      drain_done[p] = ($urandom_range(1) == 0);
            end
            pr_reset = ($urandom_range(127) == 0);
            applyStimulus(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
